// File: rtl/serial_word_packer.sv
// rtl/serial_word_packer.sv - serial-to-parallel word packer with output FIFO
//
// serial_word_packer_fifo : small synchronous FIFO holding completed words.
//    clock, rst_n     clock and asynchronous active-low reset
//    wr_en, wr_data   push request and the word to push
//    rd_ready         consumer accepts the head entry when it is valid
//    rd_data          head entry (0 while empty)
//    rd_valid         FIFO not empty
//    rd_fire          head entry consumed on this edge
//    dropped          push refused on this edge because the FIFO stayed full
//
// serial_word_packer : deserialises a qualified bit stream into DSIZE-bit
// words, aligned by a start-of-frame marker, and queues them for the consumer.
//    clock, rst_n     clock and asynchronous active-low reset
//    sin_data         serial data bit
//    sin_vld          sin_data (and sin_sof) valid this cycle
//    sin_sof          this valid bit is bit 0 of a new word
//    out_data         head-of-FIFO word
//    out_valid        FIFO not empty
//    out_ready        consumer accepts out_data when out_valid & out_ready
//    overflow         sticky: a completed word was dropped on a full FIFO
//    ovf_clr          clears overflow (a same-edge drop takes precedence)
//    frame_err        one-cycle pulse: a partial word was discarded by sin_sof
//    word_cnt         words accepted by the consumer, wraps modulo 2^16

module serial_word_packer_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic         wr_en,
   input  logic [W-1:0] wr_data,
   input  logic         rd_ready,
   output logic [W-1:0] rd_data,
   output logic         rd_valid,
   output logic         rd_fire,
   output logic         dropped
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   // One extra pointer bit distinguishes full from empty when indices match.
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         empty;
   logic         full;
   logic         accept;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

   assign rd_valid = !empty;
   assign rd_fire  = !empty && rd_ready;

   // A pop on the same edge frees the slot the push needs; when full, the
   // write index equals the head index, which is read before the edge.
   assign accept  = wr_en && (!full || rd_fire);
   assign dropped = wr_en && full && !rd_fire;

   // Force zero while empty so a stale entry never shows on out_data.
   assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else begin
         if (accept) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (rd_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

endmodule

module serial_word_packer #(
   parameter int DSIZE     = 8,
   parameter int MSB_FIRST = 1,
   parameter int DEPTH     = 4
) (
   input  logic             clock,
   input  logic             rst_n,
   input  logic             sin_data,
   input  logic             sin_vld,
   input  logic             sin_sof,
   output logic [DSIZE-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             overflow,
   input  logic             ovf_clr,
   output logic             frame_err,
   output logic [15:0]      word_cnt
);

   localparam int CW = (DSIZE > 2) ? $clog2(DSIZE) : 1;

   logic [DSIZE-1:0] shreg;
   logic [DSIZE-1:0] shreg_base;
   logic [DSIZE-1:0] shreg_next;
   logic [CW-1:0]    bit_cnt;
   logic             last_bit;
   logic             pop;
   logic             dropped;

   // A start-of-frame bit restarts the word from a clean register, so any
   // partial bits from the aborted word cannot leak into the new one.
   assign shreg_base = sin_sof ? '0 : shreg;

   always_comb begin
      shreg_next = shreg_base;
      if (MSB_FIRST != 0) begin
         shreg_next = {shreg_base[DSIZE-2:0], sin_data};
      end else begin
         shreg_next = {sin_data, shreg_base[DSIZE-1:1]};
      end
   end

   // sin_sof always leaves bit_cnt at 1, and DSIZE >= 2, so a sof bit can
   // never be the last bit of a word.
   assign last_bit = sin_vld && !sin_sof && (bit_cnt == CW'(DSIZE - 1));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         shreg     <= '0;
         bit_cnt   <= '0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= sin_vld && sin_sof && (bit_cnt != '0);
         if (sin_vld) begin
            shreg <= shreg_next;
            if (sin_sof) begin
               bit_cnt <= CW'(1);
            end else if (last_bit) begin
               bit_cnt <= '0;
            end else begin
               bit_cnt <= bit_cnt + 1'b1;
            end
         end
      end
   end

   // The completed word is pushed on the edge that captures its last bit,
   // so it is taken straight from the next-state value.
   serial_word_packer_fifo #(
      .W     (DSIZE),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock    (clock),
      .rst_n    (rst_n),
      .wr_en    (last_bit),
      .wr_data  (shreg_next),
      .rd_ready (out_ready),
      .rd_data  (out_data),
      .rd_valid (out_valid),
      .rd_fire  (pop),
      .dropped  (dropped)
   );

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         overflow <= 1'b0;
         word_cnt <= '0;
      end else begin
         if (dropped) begin
            overflow <= 1'b1;
         end else if (ovf_clr) begin
            overflow <= 1'b0;
         end
         if (pop) begin
            word_cnt <= word_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_serial_word_packer.sv
// tb/tb_serial_word_packer.sv - randomized self-checking bench for serial_word_packer

module tb_serial_word_packer;

   localparam int DSIZE = 8;
   localparam int DEPTH = 4;

   logic             clock = 1'b0;
   logic             rst_n;
   logic             sin_data;
   logic             sin_vld;
   logic             sin_sof;
   logic             out_ready;
   logic             ovf_clr;

   logic [DSIZE-1:0] m_data;
   logic             m_valid;
   logic             m_ovf;
   logic             m_ferr;
   logic [15:0]      m_cnt;
   logic [DSIZE-1:0] l_data;
   logic             l_valid;
   logic             l_ovf;
   logic             l_ferr;
   logic [15:0]      l_cnt;

   int n_checks = 0;
   int n_errors = 0;

   bit r_ready = 1'b0;
   bit r_clr   = 1'b0;

   // Reference model: received bits in arrival order, queued words stored
   // as first-bit-is-MSB values, plus the status flags.
   bit               pbits[$];
   logic [DSIZE-1:0] wq[$];
   bit               e_ovf;
   bit               e_ferr;
   logic [15:0]      e_cnt;

   always #5 clock = ~clock;

   serial_word_packer #(.DSIZE(DSIZE), .MSB_FIRST(1), .DEPTH(DEPTH)) u_msb (
      .clock(clock), .rst_n(rst_n), .sin_data(sin_data), .sin_vld(sin_vld),
      .sin_sof(sin_sof), .out_data(m_data), .out_valid(m_valid),
      .out_ready(out_ready), .overflow(m_ovf), .ovf_clr(ovf_clr),
      .frame_err(m_ferr), .word_cnt(m_cnt)
   );

   serial_word_packer #(.DSIZE(DSIZE), .MSB_FIRST(0), .DEPTH(DEPTH)) u_lsb (
      .clock(clock), .rst_n(rst_n), .sin_data(sin_data), .sin_vld(sin_vld),
      .sin_sof(sin_sof), .out_data(l_data), .out_valid(l_valid),
      .out_ready(out_ready), .overflow(l_ovf), .ovf_clr(ovf_clr),
      .frame_err(l_ferr), .word_cnt(l_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [DSIZE-1:0] bit_rev(input logic [DSIZE-1:0] w);
      logic [DSIZE-1:0] r;
      for (int i = 0; i < DSIZE; i++) r[i] = w[DSIZE-1-i];
      return r;
   endfunction

   task automatic model_reset();
      pbits.delete();
      wq.delete();
      e_ovf  = 1'b0;
      e_ferr = 1'b0;
      e_cnt  = 16'h0000;
   endtask

   task automatic model_edge(input bit d, input bit v, input bit s, input bit rdy, input bit clr);
      bit               push;
      bit               drop;
      bit               ferr;
      logic [DSIZE-1:0] w;
      push = 1'b0;
      drop = 1'b0;
      ferr = 1'b0;
      w    = '0;
      if (v) begin
         if (s) begin
            ferr = (pbits.size() != 0);
            pbits.delete();
         end
         pbits.push_back(d);
         if (pbits.size() == DSIZE) begin
            foreach (pbits[i]) w = (w << 1) | DSIZE'(pbits[i]);
            pbits.delete();
            push = 1'b1;
         end
      end
      if (rdy && wq.size() != 0) begin
         void'(wq.pop_front());
         e_cnt = e_cnt + 16'd1;
      end
      if (push) begin
         if (wq.size() < DEPTH) wq.push_back(w);
         else drop = 1'b1;
      end
      if (drop) e_ovf = 1'b1;
      else if (clr) e_ovf = 1'b0;
      e_ferr = ferr;
   endtask

   task automatic compare_all();
      check("valid_msb", 32'(m_valid), 32'(wq.size() != 0));
      check("valid_lsb", 32'(l_valid), 32'(wq.size() != 0));
      if (wq.size() != 0) begin
         check("data_msb", 32'(m_data), 32'(wq[0]));
         check("data_lsb", 32'(l_data), 32'(bit_rev(wq[0])));
      end
      check("cnt_msb", 32'(m_cnt), 32'(e_cnt));
      check("cnt_lsb", 32'(l_cnt), 32'(e_cnt));
      check("ovf_msb", 32'(m_ovf), 32'(e_ovf));
      check("ovf_lsb", 32'(l_ovf), 32'(e_ovf));
      check("ferr_msb", 32'(m_ferr), 32'(e_ferr));
      check("ferr_lsb", 32'(l_ferr), 32'(e_ferr));
   endtask

   // Called at a falling edge; drives, lets one rising edge pass, checks.
   task automatic step(input bit d, input bit v, input bit s);
      sin_data  = d;
      sin_vld   = v;
      sin_sof   = s;
      out_ready = r_ready;
      ovf_clr   = r_clr;
      @(posedge clock);
      model_edge(d, v, s, r_ready, r_clr);
      @(negedge clock);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
   endtask

   // Bits go out in first-received order w[DSIZE-1] .. w[0].
   task automatic send_word(input logic [DSIZE-1:0] w, input bit sof, input bit gaps);
      for (int i = DSIZE - 1; i >= 0; i--) begin
         step(w[i], 1'b1, sof && (i == DSIZE - 1));
         if (gaps) idle(1);
      end
   endtask

   initial begin
      rst_n = 1'b0; sin_data = 1'b0; sin_vld = 1'b0; sin_sof = 1'b0;
      out_ready = 1'b0; ovf_clr = 1'b0;
      model_reset();
      repeat (2) @(negedge clock);
      check("rst_valid", 32'({m_valid, l_valid}), 32'd0);
      check("rst_data", 32'({m_data, l_data}), 32'd0);
      check("rst_cnt", 32'({m_cnt, l_cnt}), 32'd0);
      check("rst_flags", 32'({m_ovf, l_ovf, m_ferr, l_ferr}), 32'd0);
      rst_n = 1'b1;
      idle(2);

      // Basic words, including the palindrome and the 0xC0/0x03 pair.
      r_ready = 1'b1;
      send_word(8'hA5, 1'b1, 1'b0);
      idle(2);
      check("first_word_cnt", 32'(m_cnt), 32'd1);
      send_word(8'hC0, 1'b1, 1'b0);
      idle(2);

      // Gapped valid stream.
      send_word(8'h3C, 1'b0, 1'b1);
      idle(2);

      // Three stray bits then a sof-aligned word: frame error, only 0xF0 kept.
      step(1'b1, 1'b1, 1'b0); step(1'b0, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
      send_word(8'hF0, 1'b1, 1'b0);
      idle(2);

      // Overflow: five words into a four-deep FIFO with no consumer.
      r_ready = 1'b0;
      for (int k = 1; k <= 5; k++) send_word(8'(k), 1'b0, 1'b0);
      check("ovf_after_5", 32'(m_ovf), 32'd1);
      r_ready = 1'b1;
      idle(6);
      check("cnt_after_drain", 32'(m_cnt), 32'd8);
      r_clr = 1'b1; idle(1); r_clr = 1'b0;
      idle(1);

      // Full FIFO with a pop on the very edge the next word completes.
      r_ready = 1'b0;
      for (int k = 0; k < 4; k++) send_word(8'h10 + 8'(k), 1'b0, 1'b0);
      for (int i = DSIZE - 1; i >= 1; i--) step(i[0], 1'b1, 1'b0);
      r_ready = 1'b1;
      step(1'b1, 1'b1, 1'b0);
      check("no_ovf_on_pop", 32'(m_ovf), 32'd0);
      idle(6);

      // Asynchronous reset mid-word with two words queued.
      r_ready = 1'b0;
      send_word(8'h21, 1'b0, 1'b0);
      send_word(8'h43, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0); step(1'b1, 1'b1, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      check("arst_valid", 32'({m_valid, l_valid}), 32'd0);
      check("arst_cnt", 32'({m_cnt, l_cnt}), 32'd0);
      model_reset();
      @(negedge clock);
      rst_n = 1'b1;
      r_ready = 1'b1;
      send_word(8'h5A, 1'b0, 1'b0);
      idle(3);
      check("post_rst_cnt", 32'(m_cnt), 32'd1);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         r_ready = ($urandom_range(0, 99) < 60);
         r_clr   = ($urandom_range(0, 99) < 5);
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 75),
              ($urandom_range(0, 99) < 4));
      end
      r_clr = 1'b0;
      r_ready = 1'b1;
      idle(8);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/serial_word_packer.md
Name: serial_word_packer

Overview:
- Upstream feeder for the accumulate stage.
- Deserialises a qualified serial bit stream into DSIZE-bit parallel words and presents them on a valid/ready output backed by a small FIFO.
- Frame alignment comes from a start-of-frame marker.
- Reports overflow and frame errors; keeps a running count of delivered words.

Parameters:
DSIZE, 8, width of each assembled word in bits (>=2)
MSB_FIRST, 1, 1 = first received bit lands in bit DSIZE-1; 0 = first bit lands in bit 0
DEPTH, 4, output FIFO entries (power of 2, >=2)

Ports:
clock  input  1  system clock, all logic rising-edge
rst_n  input  1  asynchronous active-low reset
sin_data  input  1  serial data bit
sin_vld  input  1  sin_data is valid this cycle
sin_sof  input  1  qualified by sin_vld: this bit is bit 0 of a new word
out_data  output  DSIZE  head-of-FIFO word
out_valid  output  1  FIFO not empty
out_ready  input  1  consumer accepts out_data when out_valid & out_ready
overflow  output  1  sticky: a completed word was dropped because the FIFO was full
ovf_clr  input  1  clears overflow
frame_err  output  1  one-cycle pulse: partial word discarded by sin_sof
word_cnt  output  16  words accepted by consumer, wraps at 16'hFFFF -> 0

Behaviour:
- Reset (async assert, sync deassert handled at top level): shift reg 0, bit_cnt 0, FIFO empty, out_valid 0, out_data 0, overflow 0, frame_err 0, word_cnt 0.
- Reset mid-word or with FIFO non-empty discards everything; no outputs glitch high.
- Shift: on each edge with sin_vld=1, the bit enters the shift register and bit_cnt increments.
  - MSB_FIRST=1: shift left, new bit enters at LSB. After DSIZE bits, the first bit sits at MSB.
  - MSB_FIRST=0: shift right, new bit enters at MSB. After DSIZE bits, the first bit sits at LSB.
- sin_vld=0: shift reg and bit_cnt hold; sin_data and sin_sof ignored.
- Word completion: edge where sin_vld=1 and bit_cnt==DSIZE-1 (including that bit). The complete word is pushed to the FIFO on that same edge and bit_cnt returns to 0.
- Latency: if the FIFO was empty, out_valid=1 and out_data=word in the cycle immediately after the last-bit edge (1-cycle latency).
- sin_sof with sin_vld=1:
  - Current bit treated as bit 0; bit_cnt becomes 1.
  - If bit_cnt was non-zero before this edge, the partial word is discarded and frame_err pulses high for exactly the following cycle.
  - sin_sof when bit_cnt==0 is legal, no error.
  - For DSIZE bits after sof, normal completion applies.
- FIFO:
  - out_valid = not empty; out_data = head entry, stable while out_valid & !out_ready.
  - Pop on out_valid & out_ready; word_cnt increments on each pop.
  - Push while full and no pop same edge: word dropped, overflow set. FIFO contents unchanged.
  - Push while full with pop same edge: push accepted, occupancy stays DEPTH, no overflow.
  - Push and pop same edge when empty is impossible (empty => no pop). Push to empty: valid next cycle.
- overflow: set by a drop, cleared by ovf_clr. If drop and ovf_clr occur on the same edge, set wins.
- Pointers: log2(DEPTH)+1 bits; full/empty from MSB compare; wrap-around is natural modulo.
- out_ready while out_valid=0 is ignored.

Test Plan:
- DSIZE=8, MSB_FIRST=1, sof on first bit, bits 1,0,1,0,0,1,0,1 back-to-back, out_ready=1 -> out_valid high one cycle after 8th bit edge with out_data=8'hA5; word_cnt=1.
- Same bits with MSB_FIRST=0 -> out_data=8'hA5 bit-reversed = 8'hA5 (palindrome); repeat with 1,1,0,0,0,0,0,0 -> 8'h03 (MSB_FIRST=0), 8'hC0 (MSB_FIRST=1).
- sin_vld gaps: bits of 8'h3C with sin_vld toggling 1,0,1,0,... -> single word 8'h3C, no extra/lost bits, no frame_err.
- 3 bits sent, then sin_sof with 8 bits of 8'hF0 -> frame_err pulses one cycle after sof edge; only 8'hF0 delivered.
- DEPTH=4, out_ready=0, send 5 words 8'h01..8'h05 -> after 5th: overflow=1, FIFO holds 01..04. Then out_ready=1 -> pops 01,02,03,04 in order, word_cnt=4. overflow remains 1 until ovf_clr pulse -> 0.
- FIFO full, out_ready=1 on the same edge a 5th word completes -> no overflow, delivered order intact. Assert rst_n low mid-word with 2 words queued -> out_valid=0, word_cnt=0 immediately; next complete word after release delivered alone.
